// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states and default width.
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_MULT = 3'b110,
        ALU_RSVD = 3'b111
    } alu_ctrl_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } exec_state_e;

    function automatic logic is_mult(input alu_ctrl_e op);
        return (op == ALU_MULT);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the issue stage, the ALU and its consumer.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, busy
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, ovf, busy
    );
endinterface

// File: rtl/alu_iter_mult.sv
// Iterative shift-add multiplier keeping the low WIDTH bits of the product.
// done is combinational in the final step so the caller can register the product on that edge.
module alu_iter_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_active;
    logic [WIDTH-1:0] w_acc_next;

    // next accumulator value for the current step
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end else begin
            w_acc_next = r_acc;
        end
    end

    assign done    = r_active && (r_cnt == {CW{1'b0}});
    assign product = w_acc_next;

    // one shift-add step per cycle while active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_active <= 1'b0;
        end else if (start) begin
            r_acc    <= {WIDTH{1'b0}};
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= CW'(WIDTH - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == {CW{1'b0}}) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and an iterative multiplier.
// Optional signed-overflow flag for add/sub is enabled by defining ALU_OVF_EN.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    exec_state_e      r_state;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_zero;
    logic [WIDTH-1:0] r_result;

    alu_ctrl_e        w_op;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_mul;
    logic             w_load_single;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic [SHW-1:0]   w_shamt;

    assign w_op          = alu_ctrl_e'(bus.alu_control);
    assign w_shamt       = bus.src_b[SHW-1:0];
    assign w_sum         = bus.src_a + bus.src_b;
    assign w_diff        = bus.src_a - bus.src_b;
    assign w_in_ready    = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_start_mul   = w_accept && is_mult(w_op);
    assign w_load_single = w_accept && !is_mult(w_op);

    // single-cycle datapath
    always_comb begin
        w_alu_res = {WIDTH{1'b0}};
        case (w_op)
            ALU_ADD:  w_alu_res = w_sum;
            ALU_XOR:  w_alu_res = bus.src_a ^ bus.src_b;
            ALU_SUB:  w_alu_res = w_diff;
            ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLL:  w_alu_res = bus.src_a << w_shamt;
            ALU_SRL:  w_alu_res = bus.src_a >> w_shamt;
            ALU_MULT: w_alu_res = {WIDTH{1'b0}};
            default:  w_alu_res = w_sum;
        endcase
    end

    alu_iter_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start_mul),
        .a       (bus.src_a),
        .b       (bus.src_b),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    // handshake FSM and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load_single) begin
                        r_result    <= w_alu_res;
                        r_zero      <= (w_alu_res == {WIDTH{1'b0}});
                        r_out_valid <= 1'b1;
                    end else if (w_start_mul) begin
                        // acceptance guarantees any pending result is retiring now
                        r_state     <= MUL;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_result    <= w_mul_prod;
                        r_zero      <= (w_mul_prod == {WIDTH{1'b0}});
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // signed overflow of add/sub, zero for every other op
    always_comb begin
        w_ovf = 1'b0;
        case (w_op)
            ALU_ADD, ALU_RSVD: w_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                                       (w_sum[WIDTH-1] != bus.src_a[WIDTH-1]);
            ALU_SUB:           w_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                                       (w_diff[WIDTH-1] != bus.src_a[WIDTH-1]);
            default:           w_ovf = 1'b0;
        endcase
    end

    // overflow flag loads in lockstep with the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == IDLE) && w_load_single) begin
            r_ovf <= w_ovf;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH = 32).
module tb_alu_exec_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   k;
    logic flag_busy;
    logic flag_rdy;
    logic flag_hold;
    logic flag_ov;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one operation and let one rising edge accept it
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        @(negedge clk);
        bus.in_valid    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_control = 3'b000;
        bus.src_a = 32'h0;
        bus.src_b = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_result", bus.result, 32'h0);
        check("rst_zero", {31'b0, bus.zero}, 32'h0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'b0, bus.in_ready}, 32'h1);

        issue(3'b000, 32'd5, 32'd7);
        check("add_valid", {31'b0, bus.out_valid}, 32'h1);
        check("add_result", bus.result, 32'd12);
        check("add_zero", {31'b0, bus.zero}, 32'h0);
        issue(3'b010, 32'd9, 32'd9);
        check("sub_result", bus.result, 32'h0);
        check("sub_zero", {31'b0, bus.zero}, 32'h1);
        issue(3'b011, 32'hFFFF_FFFF, 32'h1);
        check("slt_signed", bus.result, 32'h1);
        issue(3'b011, 32'h1, 32'hFFFF_FFFF);
        check("slt_false", bus.result, 32'h0);
        issue(3'b100, 32'h1, 32'd31);
        check("sll", bus.result, 32'h8000_0000);
        issue(3'b101, 32'h8000_0000, 32'h21);
        check("srl", bus.result, 32'h4000_0000);
        issue(3'b001, 32'hA5A5_A5A5, 32'hFFFF_0000);
        check("xor", bus.result, 32'h5A5A_A5A5);
        issue(3'b111, 32'd3, 32'd4);
        check("code7_add", bus.result, 32'd7);
        issue(3'b000, 32'hFFFF_FFFF, 32'd2);
        check("add_wrap", bus.result, 32'h1);
        check("add_wrap_ovf", {31'b0, bus.ovf}, 32'h0);
        issue(3'b000, 32'h7FFF_FFFF, 32'h1);
        check("add_big", bus.result, 32'h8000_0000);
`ifdef ALU_OVF_EN
        check("add_ovf", {31'b0, bus.ovf}, 32'h1);
        issue(3'b010, 32'h8000_0000, 32'h1);
        check("sub_ovf", {31'b0, bus.ovf}, 32'h1);
`else
        check("add_ovf_off", {31'b0, bus.ovf}, 32'h0);
`endif

        // multiply: out_valid must appear exactly 32 edges after acceptance
        issue(3'b110, 32'h0001_2345, 32'h100);
        check("mul_busy", {31'b0, bus.busy}, 32'h1);
        check("mul_in_ready", {31'b0, bus.in_ready}, 32'h0);
        check("mul_no_valid", {31'b0, bus.out_valid}, 32'h0);
        k = 0;
        flag_busy = 1'b1;
        flag_rdy = 1'b0;
        while (!bus.out_valid && k < 64) begin
            flag_busy = flag_busy & bus.busy;
            flag_rdy = flag_rdy | bus.in_ready;
            @(negedge clk);
            k++;
        end
        check("mul_latency", k, 32'd32);
        check("mul_busy_held", {31'b0, flag_busy}, 32'h1);
        check("mul_in_ready_low", {31'b0, flag_rdy}, 32'h0);
        check("mul_result", bus.result, 32'h0123_4500);
        check("mul_busy_fall", {31'b0, bus.busy}, 32'h0);

        issue(3'b110, 32'hFFFF_FFFD, 32'd7);
        k = 0;
        while (!bus.out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("mul_neg_latency", k, 32'd32);
        check("mul_neg_result", bus.result, 32'hFFFF_FFEB);

        // consumer stall for five cycles with a second op waiting
        issue(3'b000, 32'd10, 32'd20);
        bus.out_ready = 1'b0;
        check("bp_result", bus.result, 32'd30);
        bus.in_valid = 1'b1;
        bus.alu_control = 3'b010;
        bus.src_a = 32'd50;
        bus.src_b = 32'd8;
        flag_hold = 1'b1;
        flag_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            flag_hold = flag_hold & bus.out_valid & (bus.result == 32'd30);
            flag_rdy = flag_rdy | bus.in_ready;
        end
        check("bp_held", {31'b0, flag_hold}, 32'h1);
        check("bp_in_ready_low", {31'b0, flag_rdy}, 32'h0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_valid", {31'b0, bus.out_valid}, 32'h1);
        check("bp_second_result", bus.result, 32'd42);
        @(negedge clk);
        check("bp_drained", {31'b0, bus.out_valid}, 32'h0);

        // reset in the middle of a multiply
        issue(3'b110, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_in_ready", {31'b0, bus.in_ready}, 32'h1);
        flag_ov = 1'b0;
        for (int i = 0; i < 30; i++) begin
            flag_ov = flag_ov | bus.out_valid;
            @(negedge clk);
        end
        check("abort_no_valid", {31'b0, flag_ov}, 32'h0);
        issue(3'b000, 32'd1, 32'd1);
        check("post_abort_add", bus.result, 32'd2);
        check("post_abort_valid", {31'b0, bus.out_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
